// File: rtl/interrupt_sequencer.sv
// Interrupt front-end: rising-edge capture into a pending register, a mask, and
// highest-index priority. Runs the INT/INTACK/EOI handshake for one in-service vector.
module interrupt_sequencer #(
   parameter int NUM_IRQ = 8,
   parameter int VEC_W   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] IRQ,
   input  logic               MASK_WE,
   input  logic [NUM_IRQ-1:0] MASK_DIN,
   input  logic               EOI,
   input  logic               INTACK,
   output logic               INT,
   output logic [VEC_W-1:0]   INTV,
   output logic               INTV_VALID,
   output logic [NUM_IRQ-1:0] PENDING,
   output logic [NUM_IRQ-1:0] IN_SERVICE,
   output logic [NUM_IRQ-1:0] MASK
);

   typedef enum logic [1:0] {IDLE, REQ, ACK, SERVICE} state_t;

   localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

   state_t             state_reg, state_next;
   logic [NUM_IRQ-1:0] prev_reg;
   logic [NUM_IRQ-1:0] pending_reg, pending_next;
   logic [NUM_IRQ-1:0] mask_reg, mask_next;
   logic [NUM_IRQ-1:0] in_service_reg, in_service_next;
   logic               int_req_reg, int_req_next;
   logic [VEC_W-1:0]   intv_reg, intv_next;
   logic               intv_valid_reg, intv_valid_next;

   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] eligible;
   logic [NUM_IRQ-1:0] ack_clear;
   logic [VEC_W-1:0]   sel;

   assign rise     = IRQ & ~prev_reg;
   assign eligible = pending_reg & ~mask_reg;

   // Ascending scan so the highest eligible index is the last one written.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (eligible[i]) begin
            sel = VEC_W'(i);
         end
      end
   end

   // A fresh edge beats the acknowledge clear on the same bit.
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pending
         assign pending_next[gi] = (pending_reg[gi] & ~ack_clear[gi]) | rise[gi];
      end
   endgenerate

   assign mask_next = MASK_WE ? MASK_DIN : mask_reg;

   always_comb begin
      state_next      = state_reg;
      int_req_next    = int_req_reg;
      intv_next       = intv_reg;
      intv_valid_next = intv_valid_reg;
      in_service_next = in_service_reg;
      ack_clear       = '0;
      case (state_reg)
         IDLE: begin
            if (eligible != '0) begin
               state_next   = REQ;
               int_req_next = 1'b1;
            end
         end
         REQ: begin
            if (eligible == '0) begin
               state_next   = IDLE;
               int_req_next = 1'b0;
            end else if (INTACK) begin
               state_next      = ACK;
               int_req_next    = 1'b0;
               intv_next       = sel;
               intv_valid_next = 1'b1;
               ack_clear       = ONE << sel;
               in_service_next = ONE << sel;
            end
         end
         ACK: begin
            if (!INTACK) begin
               state_next      = SERVICE;
               intv_valid_next = 1'b0;
            end
         end
         SERVICE: begin
            if (EOI) begin
               state_next      = IDLE;
               in_service_next = '0;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         prev_reg       <= '0;
         pending_reg    <= '0;
         mask_reg       <= '0;
         in_service_reg <= '0;
         int_req_reg    <= 1'b0;
         intv_reg       <= '0;
         intv_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         prev_reg       <= IRQ;
         pending_reg    <= pending_next;
         mask_reg       <= mask_next;
         in_service_reg <= in_service_next;
         int_req_reg    <= int_req_next;
         intv_reg       <= intv_next;
         intv_valid_reg <= intv_valid_next;
      end
   end

   assign INT        = int_req_reg;
   assign INTV       = intv_reg;
   assign INTV_VALID = intv_valid_reg;
   assign PENDING    = pending_reg;
   assign IN_SERVICE = in_service_reg;
   assign MASK       = mask_reg;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed handshake scenarios and random traffic,
// every cycle compared against a behavioural model of the interrupt rules.
module tb_interrupt_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq;
   logic       mask_we;
   logic [7:0] mask_din;
   logic       eoi;
   logic       intack;
   logic       int_o;
   logic [2:0] intv;
   logic       intv_valid;
   logic [7:0] pending;
   logic [7:0] in_service;
   logic [7:0] mask;

   int checks = 0;
   int errors = 0;

   // Model: phase is implied by what is visible (INT up = waiting for ack,
   // in-service with valid vector = being acknowledged, in-service alone = serving).
   bit [7:0] m_prev, m_pend, m_mask, m_isr;
   bit       m_int, m_valid;
   bit [2:0] m_intv;

   always #5 clk = ~clk;

   interrupt_sequencer #(.NUM_IRQ(8), .VEC_W(3)) dut (
      .clk(clk), .rst(rst), .IRQ(irq), .MASK_WE(mask_we), .MASK_DIN(mask_din),
      .EOI(eoi), .INTACK(intack), .INT(int_o), .INTV(intv), .INTV_VALID(intv_valid),
      .PENDING(pending), .IN_SERVICE(in_service), .MASK(mask)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = '0; m_pend = '0; m_mask = '0; m_isr = '0;
      m_int = 1'b0; m_valid = 1'b0; m_intv = '0;
   endtask

   task automatic model_step();
      bit [7:0] elig;
      bit [7:0] clr;
      int top;
      elig = m_pend & ~m_mask;
      top = -1;
      for (int i = 7; i >= 0; i--) begin
         if (elig[i] && top < 0) top = i;
      end
      clr = '0;
      if (m_isr != 0) begin
         if (m_valid) begin
            if (!intack) m_valid = 1'b0;
         end else if (eoi) begin
            m_isr = '0;
         end
      end else if (m_int) begin
         if (top < 0) begin
            m_int = 1'b0;
         end else if (intack) begin
            m_intv  = 3'(top);
            m_valid = 1'b1;
            m_int   = 1'b0;
            clr     = 8'(1 << top);
            m_isr   = clr;
         end
      end else if (top >= 0) begin
         m_int = 1'b1;
      end
      m_pend = (m_pend & ~clr) | (irq & ~m_prev);
      m_prev = irq;
      if (mask_we) m_mask = mask_din;
   endtask

   task automatic compare_all();
      chk("INT", int_o, m_int);
      chk("INTV", intv, m_intv);
      chk("INTV_VALID", intv_valid, m_valid);
      chk("PENDING", pending, m_pend);
      chk("IN_SERVICE", in_service, m_isr);
      chk("MASK", mask, m_mask);
   endtask

   task automatic step(input logic [7:0] i, input logic we, input logic [7:0] d,
                       input logic e, input logic a);
      irq = i; mask_we = we; mask_din = d; eoi = e; intack = a;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      int acks;
      bit prev_valid;
      bit reached;
      logic [7:0] r_irq;

      rst = 1'b1; irq = '0; mask_we = 1'b0; mask_din = '0; eoi = 1'b0; intack = 1'b0;
      model_reset();
      #12;
      compare_all();
      rst = 1'b0;

      // Single request on line 3
      step(8'h08, 0, 0, 0, 0);  chk("single_pending", pending, 8'h08);
      step(8'h08, 0, 0, 0, 0);  chk("single_int", int_o, 1'b1);
      step(8'h08, 0, 0, 0, 1);
      chk("single_intv", intv, 3'd3); chk("single_valid", intv_valid, 1'b1);
      chk("single_pend_clr", pending, 8'h00); chk("single_isr", in_service, 8'h08);
      step(8'h08, 0, 0, 0, 1);  chk("single_hold_valid", intv_valid, 1'b1);
      step(8'h08, 0, 0, 0, 0);  chk("single_valid_drop", intv_valid, 1'b0);
      step(8'h08, 0, 0, 1, 0);  chk("single_eoi_isr", in_service, 8'h00);
      step(8'h08, 0, 0, 0, 0);  chk("single_int_quiet", int_o, 1'b0);
      step(8'h08, 0, 0, 1, 0);  // EOI while idle is ignored

      // Priority: 1 and 6 together
      step(8'h42, 0, 0, 0, 0);  chk("prio_pending", pending, 8'h42);
      step(8'h42, 0, 0, 0, 0);
      step(8'h42, 0, 0, 0, 1);  chk("prio_first", intv, 3'd6);
      step(8'h42, 0, 0, 0, 0);
      step(8'h42, 0, 0, 1, 0);
      step(8'h42, 0, 0, 0, 0);  chk("prio_reassert", int_o, 1'b1);
      step(8'h42, 0, 0, 0, 1);  chk("prio_second", intv, 3'd1);
      step(8'h42, 0, 0, 0, 0);
      step(8'h42, 0, 0, 1, 0);

      // Mask
      step(8'h42, 1, 8'h80, 0, 0);
      step(8'hC2, 0, 0, 0, 0);  chk("mask_pending", pending, 8'h80);
      step(8'hC2, 0, 0, 0, 0);  chk("mask_int_low", int_o, 1'b0);
      step(8'hC2, 1, 8'h00, 0, 0);
      step(8'hC2, 0, 0, 0, 0);  chk("unmask_int", int_o, 1'b1);
      step(8'hC2, 1, 8'h80, 0, 0);
      step(8'hC2, 0, 0, 0, 0);
      chk("remask_int", int_o, 1'b0); chk("remask_pending", pending, 8'h80);
      step(8'hC2, 1, 8'h00, 0, 0);
      step(8'hC2, 0, 0, 0, 0);
      step(8'hC2, 0, 0, 0, 1);  chk("mask_vec7", intv, 3'd7);
      step(8'hC2, 0, 0, 0, 0);
      step(8'hC2, 0, 0, 1, 0);

      // Overlap: line 5 arrives while 2 is in service
      step(8'hC6, 0, 0, 0, 0);
      step(8'hC6, 0, 0, 0, 0);
      step(8'hC6, 0, 0, 0, 1);  chk("ovl_vec2", intv, 3'd2);
      step(8'hC6, 0, 0, 0, 0);
      step(8'hE6, 0, 0, 0, 1);  chk("ovl_int_blocked", int_o, 1'b0);
      step(8'hE6, 0, 0, 0, 1);  chk("ovl_intack_ignored", in_service, 8'h04);
      step(8'hE6, 0, 0, 1, 0);
      step(8'hE6, 0, 0, 0, 0);  chk("ovl_int_after_eoi", int_o, 1'b1);
      step(8'hE6, 0, 0, 0, 1);  chk("ovl_vec5", intv, 3'd5);
      step(8'hE6, 0, 0, 0, 0);
      step(8'hE6, 0, 0, 1, 0);

      // Edge on 2 during its own acknowledge-clear cycle
      step(8'hE2, 0, 0, 0, 0);
      step(8'hE6, 0, 0, 0, 0);
      step(8'hE2, 0, 0, 0, 0);
      step(8'hE6, 0, 0, 0, 1);
      chk("collide_vec", intv, 3'd2); chk("collide_pending", pending, 8'h04);
      step(8'hE6, 0, 0, 0, 0);
      step(8'hE6, 0, 0, 1, 0);
      step(8'hE6, 0, 0, 0, 0);
      step(8'hE6, 0, 0, 0, 1);
      step(8'hE6, 0, 0, 0, 0);
      step(8'hE6, 0, 0, 1, 0);

      // Level hold on line 4: exactly one acknowledge
      acks = 0;
      prev_valid = intv_valid;
      for (int k = 0; k < 20; k++) begin
         step(8'hF6, 0, 0, (m_isr != 0) && !m_valid, m_int);
         if (intv_valid && !prev_valid) acks++;
         prev_valid = intv_valid;
      end
      chk("level_one_ack", acks, 1);

      // Random traffic
      r_irq = 8'hF6;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) r_irq[$urandom_range(0, 7)] ^= 1'b1;
         step(r_irq, $urandom_range(0, 15) == 0, 8'($urandom & $urandom & $urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
      end

      // Reach ACK, then reset asynchronously
      reached = 1'b0;
      r_irq = 8'h00;
      for (int k = 0; k < 40 && !reached; k++) begin
         r_irq ^= 8'h10;
         step(r_irq, 1, 8'h00, 1, 1);
         reached = m_valid;
      end
      chk("reach_ack", reached, 1'b1);
      #2;
      rst = 1'b1; irq = 8'h01; mask_we = 1'b0; eoi = 1'b0; intack = 1'b0;
      #1;
      model_reset();
      chk("rst_int", int_o, 1'b0);
      chk("rst_valid", intv_valid, 1'b0);
      chk("rst_isr", in_service, 8'h00);
      compare_all();
      #3;
      rst = 1'b0;
      step(8'h01, 0, 0, 0, 0);  chk("rst_release_edge", pending, 8'h01);
      step(8'h01, 0, 0, 0, 0);  chk("rst_release_int", int_o, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Clocked interrupt front-end for the Vertebrate CPU. Collects 8 IRQ lines, latches rising edges into a pending register, applies a mask, and picks the highest-priority eligible request (highest index wins).
- Runs the INT/INTACK handshake with the CPU core and presents the vector.
- Tracks the one interrupt currently in service until software signals end-of-interrupt (EOI). No nesting.

Parameters:
- NUM_IRQ, 8, number of request lines (behaviour below is written for 8).
- VEC_W, 3, vector width, equal to clog2(NUM_IRQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- IRQ  in  NUM_IRQ  request lines, synchronous to clk; rising edge requests service.
- MASK_WE  in  1  write strobe for the mask register.
- MASK_DIN  in  NUM_IRQ  mask data; bit=1 disables that line.
- EOI  in  1  one-cycle end-of-interrupt pulse from the CPU.
- INTACK  in  1  CPU acknowledge level.
- INT  out  1  interrupt request to the CPU.
- INTV  out  VEC_W  acknowledged vector.
- INTV_VALID  out  1  INTV is valid for the current acknowledge.
- PENDING  out  NUM_IRQ  pending register, for status reads.
- IN_SERVICE  out  NUM_IRQ  one-hot in-service register, or zero.
- MASK  out  NUM_IRQ  current mask register.

Behaviour:
- Reset (async, active-high): state=IDLE; INT=0, INTV=0, INTV_VALID=0, PENDING=0, IN_SERVICE=0, MASK=0 (all lines enabled); edge-detect history=0.
  - A line held high when reset releases therefore registers as one edge.
  - Asserting rst mid-handshake aborts everything immediately; no request survives.
- Edge detect: prev<=IRQ every cycle. If IRQ[i] & ~prev[i] at edge n, PENDING[i] is set at edge n+1. Levels are never re-counted.
- Mask: if MASK_WE is high at an edge, MASK<=MASK_DIN.
  - Masked bits stay pending but are not eligible.
  - eligible = PENDING & ~MASK.
  - sel = index of the highest set bit of eligible.
- All outputs are registered.
- FSM states: IDLE, REQ, ACK, SERVICE.
  - IDLE: if eligible!=0, go to REQ and set INT=1 on the same edge. Worst-case latency from the IRQ rising edge being sampled to INT=1 is 2 clocks.
  - REQ: INT held at 1.
    - If eligible becomes 0 (mask write), go to IDLE, INT=0.
    - If INTACK=1: INTV<=sel, where sel is evaluated in that cycle, so priority can change until acknowledge. Also INTV_VALID<=1, INT<=0, PENDING[sel]<=0, IN_SERVICE<=onehot(sel), go to ACK.
  - ACK: INTV and INTV_VALID held while INTACK=1. When INTACK=0: INTV_VALID<=0, go to SERVICE.
  - SERVICE: INTACK is ignored; new edges still accumulate in PENDING. When EOI=1: IN_SERVICE<=0, go to IDLE. A new request can raise INT 1 clock after EOI.
- Ignored inputs: EOI outside SERVICE; INTACK in IDLE or SERVICE.
- Simultaneous events on one bit: if a new edge on bit i arrives in the same cycle PENDING[i] is cleared by acknowledge, the set wins (PENDING[i]=1 afterwards).
- Mask during service: a mask write does not affect IN_SERVICE or an acknowledge already in progress.
- INTV keeps its last value after service completes.
- Vector width: sel is an unsigned VEC_W-bit index. All-zero eligible never reaches acknowledge, because REQ requires eligible!=0.

Test Plan:
- Single request: IRQ[3] 0->1 at cycle 0 -> PENDING=8'h08 at cycle 1, INT=1 by cycle 2. INTACK high for 2 cycles -> INTV=3, INTV_VALID=1, PENDING=0, IN_SERVICE=8'h08. INTACK low -> SERVICE. EOI pulse -> IN_SERVICE=0, state IDLE, INT stays 0.
- Priority: edges on IRQ[1] and IRQ[6] in the same cycle -> first acknowledge gives INTV=6. After EOI, INT reasserts and the second acknowledge gives INTV=1.
- Mask: MASK_DIN=8'h80 written, then IRQ[7] edge -> PENDING=8'h80, INT stays 0. Writing MASK=0 -> INT=1 within 1 clock. Masking the sole request while in REQ -> INT drops, state IDLE, PENDING retained.
- Overlap: IRQ[5] edge arrives during SERVICE of vector 2 -> INT stays 0 until EOI, then asserts and the acknowledge gives INTV=5. An IRQ[2] edge in the acknowledge-clear cycle of bit 2 -> PENDING[2]=1 afterwards.
- Level hold and stray inputs: IRQ[4] held high for 20 cycles -> exactly one acknowledge. EOI in IDLE and INTACK in SERVICE -> no state or register change.
- Reset: rst asserted while in ACK -> all outputs 0 asynchronously. IRQ[0] high at reset release -> PENDING[0]=1 one clock later.
